// File: rtl/move_command_gen_pkg.sv
// ---------------------------------------------------------------------------
// move_cmd_pkg
// Shared types for the button-to-movement-command path:
//   cmd_t    3-bit movement command (0 none, 1 left, 2 right, 3 up, 4 down)
//   state_t  emission FSM states (IDLE, ARMED, HOLD)
//   prio_encode  fixed-priority encode of debounced levels
//                (left > right > up > down)
//   umax     larger of two unsigned values, used to size the repeat counter
// ---------------------------------------------------------------------------
package move_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_LEFT  = 3'd1,
        CMD_RIGHT = 3'd2,
        CMD_UP    = 3'd3,
        CMD_DOWN  = 3'd4
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic cmd_t prio_encode(input logic left, input logic right,
                                         input logic up,   input logic down);
        if (left)       return CMD_LEFT;
        else if (right) return CMD_RIGHT;
        else if (up)    return CMD_UP;
        else if (down)  return CMD_DOWN;
        else            return CMD_NONE;
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/move_command_gen_if.sv
// ---------------------------------------------------------------------------
// move_command_gen_if
// Bundles the raw button inputs, the frame tick and the movement command.
//   btn_left/right/up/down  raw active-high buttons (asynchronous to clk)
//   frame_tick              one-cycle pulse per display frame
//   command                 registered movement command pulse
// Modports:
//   master  stimulus side (drives buttons and tick, reads command)
//   slave   command generator side
// ---------------------------------------------------------------------------
interface move_command_gen_if;
    import move_cmd_pkg::*;

    logic btn_left;
    logic btn_right;
    logic btn_up;
    logic btn_down;
    logic frame_tick;
    cmd_t command;

    modport master (
        output btn_left, btn_right, btn_up, btn_down, frame_tick,
        input  command
    );

    modport slave (
        input  btn_left, btn_right, btn_up, btn_down, frame_tick,
        output command
    );
endinterface

// File: rtl/move_command_gen_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a stability counter for one raw button.
// The debounced level flips only after the synchronised sample has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample clears
// the counter.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   btn_raw    raw button input (asynchronous to clk)
//   btn_level  debounced button level
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level
);

    // Counter only has to reach DEBOUNCE_CYCLES-1: the flip happens on the
    // edge that would otherwise take it to DEBOUNCE_CYCLES.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;

endmodule

// File: rtl/move_command_gen.sv
// ---------------------------------------------------------------------------
// move_command_gen
// Turns four raw push-buttons into single-cycle movement command pulses,
// aligned to frame_tick so the object moves one step per frame.
// Each button is synchronised and debounced, the debounced levels are
// priority encoded (left > right > up > down), and a three-state FSM decides
// when to emit. command is registered and is nonzero for exactly one cycle
// per step, in the cycle after the qualifying frame_tick edge.
//
// Optional feature macro: AUTO_REPEAT_EN
//   defined   : a held direction re-emits after REPEAT_DELAY frame ticks and
//               then every REPEAT_PERIOD frame ticks.
//   undefined : one command per debounced press or direction change; the
//               repeat counter is not built.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    move_command_gen_if.slave (buttons, frame_tick, command)
// ---------------------------------------------------------------------------
module move_command_gen
    import move_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 20,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    move_command_gen_if.slave     bus
);

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("move_command_gen: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic lvl_left, lvl_right, lvl_up, lvl_down;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .reset(reset), .btn_raw(bus.btn_left),  .btn_level(lvl_left)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .reset(reset), .btn_raw(bus.btn_right), .btn_level(lvl_right)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .reset(reset), .btn_raw(bus.btn_up),    .btn_level(lvl_up)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .reset(reset), .btn_raw(bus.btn_down),  .btn_level(lvl_down)
    );

    cmd_t   dir_now;
    state_t state_q, state_d;
    cmd_t   dir_q,   dir_d;
    cmd_t   cmd_q,   cmd_d;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RCNT_MAX = umax(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned RCNT_W   = $clog2(RCNT_MAX + 1);
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
`endif

    always_comb begin
        dir_now = prio_encode(lvl_left, lvl_right, lvl_up, lvl_down);
    end

    // Release and direction change are tested before frame_tick, so they win
    // over an emission in the same cycle.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cmd_d   = CMD_NONE;
`ifdef AUTO_REPEAT_EN
        rcnt_d  = rcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (dir_now != CMD_NONE) begin
                    state_d = ARMED;
                    dir_d   = dir_now;
                end
            end
            ARMED: begin
                if (dir_now == CMD_NONE) begin
                    state_d = IDLE;
                    dir_d   = CMD_NONE;
                end else if (dir_now != dir_q) begin
                    dir_d = dir_now;
                end else if (bus.frame_tick) begin
                    cmd_d   = dir_q;
                    state_d = HOLD;
`ifdef AUTO_REPEAT_EN
                    rcnt_d  = RCNT_W'(REPEAT_DELAY);
`endif
                end
            end
            HOLD: begin
                if (dir_now == CMD_NONE) begin
                    state_d = IDLE;
                    dir_d   = CMD_NONE;
                end else if (dir_now != dir_q) begin
                    state_d = ARMED;
                    dir_d   = dir_now;
                end else if (bus.frame_tick) begin
`ifdef AUTO_REPEAT_EN
                    // Emit on the tick that takes rcnt to zero and reload
                    // in the same step, so rcnt never wraps.
                    if (rcnt_q <= RCNT_W'(1)) begin
                        cmd_d  = dir_q;
                        rcnt_d = RCNT_W'(REPEAT_PERIOD);
                    end else begin
                        rcnt_d = rcnt_q - RCNT_W'(1);
                    end
`else
                    cmd_d = CMD_NONE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                dir_d   = CMD_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= CMD_NONE;
            cmd_q   <= CMD_NONE;
`ifdef AUTO_REPEAT_EN
            rcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cmd_q   <= cmd_d;
`ifdef AUTO_REPEAT_EN
            rcnt_q  <= rcnt_d;
`endif
        end
    end

    assign bus.command = cmd_q;

endmodule

// File: tb/tb_move_command_gen.sv
`timescale 1ns/1ps
module tb_move_command_gen;
    import move_cmd_pkg::*;

    localparam int DB = 4;
    localparam int RD = 3;
    localparam int RP = 2;
    localparam int TICK_PERIOD = 10;
`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    move_command_gen_if bus();

    move_command_gen #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: button level history and emission bookkeeping.
    logic [3:0] m_d1, m_d2, m_lvl;
    int m_run[4];
    int m_dir;      // direction currently tracked, 0 when none
    bit m_wait;     // tracked direction still owes its first emission
    int m_left;     // frame ticks until the next auto-repeat

    int prev_cmd;
    int pulse_cnt;
    int last_val;
    int pulse_cyc[$];
    int pulse_val[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_lvl = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_dir = 0; m_wait = 1'b0; m_left = 0;
        prev_cmd = 0;
    endtask

    function automatic int prio(input logic [3:0] l);
        if (l[0]) return 1;
        if (l[1]) return 2;
        if (l[2]) return 3;
        if (l[3]) return 4;
        return 0;
    endfunction

    task automatic set_btns(input logic [3:0] b);
        bus.btn_left  = b[0];
        bus.btn_right = b[1];
        bus.btn_up    = b[2];
        bus.btn_down  = b[3];
    endtask

    task automatic clear_pulses();
        pulse_cnt = 0;
        last_val = 0;
        pulse_cyc.delete();
        pulse_val.delete();
    endtask

    // One clock: drive tick, advance the model, compare after the edge.
    task automatic step();
        logic [3:0] raw;
        int now, e, act;
        bus.frame_tick = (cyc % TICK_PERIOD == TICK_PERIOD - 1);
        raw = {bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};
        now = prio(m_lvl);
        e = 0;
        if (now == 0) begin
            m_dir = 0; m_wait = 1'b0;
        end else if (now != m_dir) begin
            m_dir = now; m_wait = 1'b1;
        end else if (bus.frame_tick) begin
            if (m_wait) begin
                e = now; m_wait = 1'b0; m_left = RD;
            end else if (AR) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    e = now; m_left = RP;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (m_d2[i] != m_lvl[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_d2 = m_d1;
        m_d1 = raw;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        act = int'(bus.command);
        check("command", act, e);
        if (prev_cmd != 0) check("no_back_to_back", act, 0);
        if (act != 0) begin
            pulse_cnt++;
            last_val = act;
            pulse_cyc.push_back(cyc);
            pulse_val.push_back(act);
        end
        prev_cmd = act;
    endtask

    task automatic wait_pulse(input int max_cycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            step();
            if (bus.command != CMD_NONE) found = 1'b1;
        end
    endtask

    typedef struct {
        string      name;
        logic [3:0] btns;
        int         hold;
        int         exp_pulses;
        int         exp_val;
    } vec_t;

    vec_t vecs[8];

    task automatic hold_long(input string name, input logic [3:0] b, input int val);
        int rel_cyc, late;
        clear_pulses();
        set_btns(b);
        repeat (100) step();
        set_btns(4'b0000);
        rel_cyc = cyc;
        repeat (40) step();
        late = 0;
        foreach (pulse_cyc[i]) if (pulse_cyc[i] > rel_cyc + 6) late++;
        check({name, "_after_release"}, late, 0);
        foreach (pulse_val[i]) check({name, "_value"}, pulse_val[i], val);
        if (AR) begin
            check({name, "_count_4_or_5"}, int'(pulse_cnt == 4 || pulse_cnt == 5), 1);
            for (int i = 1; i < pulse_cyc.size(); i++)
                check({name, "_gap"}, pulse_cyc[i] - pulse_cyc[i-1],
                      (i == 1) ? RD * TICK_PERIOD : RP * TICK_PERIOD);
        end else begin
            check({name, "_count"}, pulse_cnt, 1);
        end
    endtask

    initial begin
        bit found;

        vecs[0] = '{"glitch_left_3",  4'b0001,  3, 0, 0};
        vecs[1] = '{"left_20",        4'b0001, 20, 1, 1};
        vecs[2] = '{"right_down_20",  4'b1010, 20, 1, 2};
        vecs[3] = '{"up_20",          4'b0100, 20, 1, 3};
        vecs[4] = '{"all_four_20",    4'b1111, 20, 1, 1};
        vecs[5] = '{"down_20",        4'b1000, 20, 1, 4};
        vecs[6] = '{"up_down_20",     4'b1100, 20, 1, 3};
        vecs[7] = '{"none_20",        4'b0000, 20, 0, 0};

        // Power-on reset.
        set_btns(4'b0000);
        bus.frame_tick = 1'b0;
        reset = 1'b1;
        model_reset();
        clear_pulses();
        repeat (3) @(negedge clk);
        check("reset_command", int'(bus.command), 0);
        reset = 1'b0;

        // Table-driven press/release patterns.
        foreach (vecs[v]) begin
            clear_pulses();
            set_btns(vecs[v].btns);
            repeat (vecs[v].hold) step();
            set_btns(4'b0000);
            repeat (25) step();
            check({vecs[v].name, "_pulses"}, pulse_cnt, vecs[v].exp_pulses);
            if (vecs[v].exp_pulses > 0) check({vecs[v].name, "_value"}, last_val, vecs[v].exp_val);
        end

        // Asynchronous reset while a pulse is on the output.
        clear_pulses();
        set_btns(4'b0001);
        wait_pulse(60, found);
        check("midpulse_found", int'(found), 1);
        set_btns(4'b0000);
        bus.frame_tick = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("reset_async_command", int'(bus.command), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_held_command", int'(bus.command), 0);
        reset = 1'b0;
        clear_pulses();
        repeat (30) step();
        check("post_reset_idle_pulses", pulse_cnt, 0);

        // Long holds (auto-repeat behaviour depends on the build).
        hold_long("hold_up", 4'b0100, 3);
        hold_long("hold_down", 4'b1000, 4);

        // Right+down, then release right while down is held.
        clear_pulses();
        set_btns(4'b1010);
        repeat (20) step();
        set_btns(4'b1000);
        repeat (20) step();
        set_btns(4'b0000);
        repeat (25) step();
        check("rd_pulse_count", pulse_cnt, 2);
        if (pulse_val.size() == 2) begin
            check("rd_first", pulse_val[0], 2);
            check("rd_second", pulse_val[1], 4);
        end

        // Release landing on the tick that would carry the first repeat.
        clear_pulses();
        set_btns(4'b0001);
        wait_pulse(40, found);
        check("release_tick_found", int'(found), 1);
        clear_pulses();
        repeat (23) step();
        set_btns(4'b0000);
        repeat (40) step();
        check("release_tick_no_emit", pulse_cnt, 0);
        check("release_tick_fsm_idle", int'(dut.state_q), int'(IDLE));

        // Randomised button activity against the model.
        for (int s = 0; s < 200; s++) begin
            set_btns(4'($urandom_range(0, 15)));
            repeat ($urandom_range(1, 30)) step();
        end
        set_btns(4'b0000);
        repeat (30) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
